// File: rtl/prog_timer_if.sv
// rtl/prog_timer_if.sv - control and status bundle for the programmable seconds timer
interface prog_timer_if #(
  parameter int SEC_W = 4
);
  logic             load;
  logic             en;
  logic             auto_reload;
  logic             clear;
  logic [SEC_W-1:0] t_default;
  logic             waited;
  logic             expire_pulse;
  logic             expired;
  logic             running;
  logic [SEC_W-1:0] t_display;

  modport master (
    output load, en, auto_reload, clear, t_default,
    input  waited, expire_pulse, expired, running, t_display
  );

  modport slave (
    input  load, en, auto_reload, clear, t_default,
    output waited, expire_pulse, expired, running, t_display
  );
endinterface

// File: rtl/prog_timer.sv
// rtl/prog_timer.sv - seconds countdown timer with one-shot and periodic modes
module prog_timer #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int SEC_W         = 4
) (
  input  logic         clock,
  input  logic         reset,
  prog_timer_if.slave  bus
);
  // Prescaler counts TICKS_PER_SEC-1 down to 0, so clog2 bits always hold it.
  localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [PRE_W-1:0] prescaler;
  logic [SEC_W-1:0] sec;
  logic [SEC_W-1:0] reload;
  logic             expired_q;
  logic             pulse_q;
  logic             sec_tick;
  logic             expiry;

  // A whole second elapses when an enabled count finds the prescaler at zero;
  // it is an expiry when that was the last remaining second.
  always_comb begin
    sec_tick = (state == S_COUNT) && bus.en && (prescaler == '0);
    expiry   = sec_tick && (sec <= SEC_W'(1));
  end

  // Countdown state: reset beats load, load beats counting, clear runs alongside.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      prescaler <= '0;
      sec       <= '0;
      reload    <= '0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (bus.load) begin
        sec       <= bus.t_default;
        reload    <= bus.t_default;
        prescaler <= PRE_MAX;
        expired_q <= 1'b0;
        if (bus.t_default == '0) begin
          // A zero-length countdown finishes immediately.
          state   <= S_DONE;
          pulse_q <= 1'b1;
        end else begin
          state <= S_COUNT;
        end
      end else begin
        if (state == S_COUNT && bus.en) begin
          if (prescaler != '0) begin
            prescaler <= prescaler - PRE_W'(1);
          end else begin
            prescaler <= PRE_MAX;
            if (expiry) begin
              pulse_q <= 1'b1;
              // auto_reload is only looked at here, so mid-count changes wait for expiry.
              if (bus.auto_reload) begin
                sec <= reload;
              end else begin
                sec   <= '0;
                state <= S_DONE;
              end
            end else begin
              sec <= sec - SEC_W'(1);
            end
          end
        end
        // Set wins over a coincident clear.
        if (expiry) begin
          expired_q <= 1'b1;
        end else if (bus.clear) begin
          expired_q <= 1'b0;
        end
      end
    end
  end

  assign bus.waited       = (state == S_DONE) && bus.en;
  assign bus.running      = (state == S_COUNT) && bus.en;
  assign bus.t_display    = sec;
  assign bus.expired      = expired_q;
  assign bus.expire_pulse = pulse_q;
endmodule

// File: doc/prog_timer.md
PROG_TIMER -- requirements
Module: prog_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100_000_000: clock cycles per displayed second; SHALL be >= 2.
REQ-002 Parameter SEC_W, default 4: width of the seconds count, reload value and display.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock only.
REQ-005 load  input  1  loads t_default and restarts the countdown.
REQ-006 en  input  1  count enable; gates waited.
REQ-007 auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled on the expiry cycle.
REQ-008 clear  input  1  clears the sticky expired flag.
REQ-009 t_default  input  SEC_W  countdown length in seconds.
REQ-010 waited  output  1  one-shot done, gated by en.
REQ-011 expire_pulse  output  1  one-cycle pulse per expiry.
REQ-012 expired  output  1  sticky expiry flag.
REQ-013 running  output  1  counting this cycle.
REQ-014 t_display  output  SEC_W  remaining whole seconds.

Function
REQ-015 States SHALL be IDLE (nothing loaded), COUNT and DONE.
REQ-016 Registers SHALL be:
- prescaler: width clog2(TICKS_PER_SEC);
- sec and reload: SEC_W each.
- No multiply of t_default by TICKS_PER_SEC; no overflow for any parameter set.
REQ-017 Priority per edge SHALL be reset > load > counting; clear SHALL be evaluated in parallel.
REQ-018 load SHALL set sec = reload = t_default and prescaler = TICKS_PER_SEC-1, in any state and regardless of en.
- t_default != 0: next state COUNT, expire_pulse not asserted.
- t_default == 0: next state DONE, expire_pulse asserted the following cycle.
REQ-019 COUNT with en=0: prescaler and sec SHALL hold (pause).
REQ-020 COUNT with en=1 and prescaler != 0: prescaler SHALL decrement by 1.
REQ-021 COUNT with en=1 and prescaler == 0: prescaler SHALL reload to TICKS_PER_SEC-1, and:
- sec > 1: sec decrements by 1.
- sec == 1: expiry, per REQ-022.
REQ-022 On expiry:
- auto_reload=0: sec = 0, next state DONE.
- auto_reload=1: sec = reload, state stays COUNT.
- Both modes: expire_pulse high for exactly the next cycle; expired set.
REQ-023 Latency: with en held high from the load edge, the expiry edge SHALL be t_default*TICKS_PER_SEC clock edges after the load edge.
- t_display shows t_default for the first TICKS_PER_SEC cycles, then decrements once per TICKS_PER_SEC cycles.
REQ-024 DONE and IDLE SHALL hold all counters; only load leaves them.
REQ-025 expired SHALL be cleared by load or clear; an expiry on the same edge as clear SHALL set expired (set wins).
REQ-026 waited SHALL equal (state==DONE) AND en, combinationally; it never asserts in auto_reload periodic operation.
REQ-027 running SHALL equal (state==COUNT) AND en, combinationally.
REQ-028 t_display SHALL equal sec at all times.
REQ-029 Change of auto_reload mid-count SHALL take effect only at the next expiry.
REQ-030 All outputs except waited and running SHALL be registered.

Reset
REQ-031 Reset (reset=0 at a rising edge) SHALL force the following, overriding load and all other inputs:
- state IDLE;
- prescaler, sec and reload 0;
- expired 0, expire_pulse 0.
REQ-032 Reset values SHALL therefore be waited=0, running=0, t_display=0, expired=0, expire_pulse=0.
REQ-033 Reset asserted mid-count SHALL abort the countdown with no expire_pulse; counting resumes only after a new load.

Verification (TICKS_PER_SEC=4, SEC_W=4)
REQ-034 One-shot: load with t_default=3, en=1, auto_reload=0 -> t_display 3,2,1,0 at 4-cycle steps; expire_pulse one cycle after edge 12; waited=1 afterwards; waited drops to 0 when en=0.
REQ-035 Pause: t_default=2, en low for 5 cycles mid-count -> expiry delayed by exactly 5 cycles; running=0 during the pause.
REQ-036 Periodic: t_default=2, auto_reload=1 -> expire_pulse every 8 cycles; t_display 2,1,2,1...; waited stays 0; expired stays 1.
REQ-037 Zero and reload: load t_default=0 -> DONE, expire_pulse next cycle; a load at cycle 5 of a 3 s count restarts the countdown at the new value.
REQ-038 clear coincident with the expiry edge -> expired=1; clear on a later cycle -> expired=0.
REQ-039 reset=0 during COUNT -> all outputs 0 on the next cycle; no expire_pulse; load and reset asserted together -> reset wins.
